// File: rtl/n1_dsp_mul_arb.sv
// Round-robin arbiter sharing one DSP multiplier between the ALU (port 0) and the
// co-processor slot (port 1): grant, register operands onto the DSP, return the product.
module n1_dsp_mul_arb #(
    parameter int OPD_WIDTH = 16,
    parameter int RES_WIDTH = 32,
    parameter int RR_INIT   = 0
) (
    input  logic                 clk_i,
    input  logic                 async_rst_i,
    input  logic                 sync_rst_i,

    input  logic                 req0_stb_i,
    input  logic                 req0_sel_i,
    input  logic [OPD_WIDTH-1:0] req0_opd0_i,
    input  logic [OPD_WIDTH-1:0] req0_opd1_i,
    output logic                 req0_ack_o,
    output logic [RES_WIDTH-1:0] req0_res_o,

    input  logic                 req1_stb_i,
    input  logic                 req1_sel_i,
    input  logic [OPD_WIDTH-1:0] req1_opd0_i,
    input  logic [OPD_WIDTH-1:0] req1_opd1_i,
    output logic                 req1_ack_o,
    output logic [RES_WIDTH-1:0] req1_res_o,

    output logic                 arb2dsp_mul_sel_o,
    output logic [OPD_WIDTH-1:0] arb2dsp_mul_opd0_o,
    output logic [OPD_WIDTH-1:0] arb2dsp_mul_opd1_o,
    input  logic [RES_WIDTH-1:0] dsp2arb_mul_res_i,

    output logic                 arb_busy_o
);

    localparam logic PTR_INIT = (RR_INIT != 0);

    logic [1:0]           pend_q, pend_d;
    logic                 ptr_q, ptr_d;
    logic                 s1_vld_q, s1_vld_d;
    logic                 s1_tag_q, s1_tag_d;
    logic                 s2_vld_q, s2_vld_d;
    logic                 s2_tag_q, s2_tag_d;
    logic                 sel_q, sel_d;
    logic [OPD_WIDTH-1:0] opd0_q, opd0_d;
    logic [OPD_WIDTH-1:0] opd1_q, opd1_d;
    logic [RES_WIDTH-1:0] res0_q, res0_d;
    logic [RES_WIDTH-1:0] res1_q, res1_d;

    logic [1:0]           elig;
    logic [1:0]           ack;
    logic                 gnt_vld;
    logic                 gnt_idx;

    // A port with an operation in flight sits out arbitration until its ack.
    assign elig    = {req1_stb_i & ~pend_q[1], req0_stb_i & ~pend_q[0]};
    assign ack     = {s2_vld_q & s2_tag_q, s2_vld_q & ~s2_tag_q};
    assign gnt_vld = |elig;
    assign gnt_idx = (&elig) ? ptr_q : elig[1];

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through this block
        // leaves a signal unassigned -- otherwise synthesis infers a latch.
        pend_d   = pend_q & ~ack;
        ptr_d    = ptr_q;
        s1_vld_d = gnt_vld;
        s1_tag_d = gnt_idx;
        s2_vld_d = s1_vld_q;
        s2_tag_d = s1_tag_q;
        sel_d    = sel_q;
        opd0_d   = opd0_q;
        opd1_d   = opd1_q;
        res0_d   = res0_q;
        res1_d   = res1_q;

        // Operands hold when idle so the DSP inputs do not toggle.
        if (gnt_vld) begin
            pend_d[gnt_idx] = 1'b1;
            ptr_d           = ~gnt_idx;
            sel_d           = gnt_idx ? req1_sel_i  : req0_sel_i;
            opd0_d          = gnt_idx ? req1_opd0_i : req0_opd0_i;
            opd1_d          = gnt_idx ? req1_opd1_i : req0_opd1_i;
        end

        if (s1_vld_q) begin
            if (s1_tag_q) begin
                res1_d = dsp2arb_mul_res_i;
            end else begin
                res0_d = dsp2arb_mul_res_i;
            end
        end

        if (sync_rst_i) begin
            pend_d   = '0;
            ptr_d    = PTR_INIT;
            s1_vld_d = 1'b0;
            s1_tag_d = 1'b0;
            s2_vld_d = 1'b0;
            s2_tag_d = 1'b0;
            sel_d    = 1'b0;
            opd0_d   = '0;
            opd1_d   = '0;
            res0_d   = '0;
            res1_d   = '0;
        end
    end

    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            pend_q   <= '0;
            ptr_q    <= PTR_INIT;
            s1_vld_q <= 1'b0;
            s1_tag_q <= 1'b0;
            s2_vld_q <= 1'b0;
            s2_tag_q <= 1'b0;
            sel_q    <= 1'b0;
            opd0_q   <= '0;
            opd1_q   <= '0;
            res0_q   <= '0;
            res1_q   <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of the others.
            pend_q   <= pend_d;
            ptr_q    <= ptr_d;
            s1_vld_q <= s1_vld_d;
            s1_tag_q <= s1_tag_d;
            s2_vld_q <= s2_vld_d;
            s2_tag_q <= s2_tag_d;
            sel_q    <= sel_d;
            opd0_q   <= opd0_d;
            opd1_q   <= opd1_d;
            res0_q   <= res0_d;
            res1_q   <= res1_d;
        end
    end

    assign req0_ack_o         = ack[0];
    assign req1_ack_o         = ack[1];
    assign req0_res_o         = res0_q;
    assign req1_res_o         = res1_q;
    assign arb2dsp_mul_sel_o  = sel_q;
    assign arb2dsp_mul_opd0_o = opd0_q;
    assign arb2dsp_mul_opd1_o = opd1_q;
    assign arb_busy_o         = s1_vld_q | s2_vld_q;

endmodule

// File: tb/tb_n1_dsp_mul_arb.sv
// Self-checking bench for n1_dsp_mul_arb: directed scenarios plus random traffic,
// compared every cycle against a queue-of-operations reference model.
module tb_n1_dsp_mul_arb;

    localparam int W       = 16;
    localparam int RW      = 32;
    localparam int RR_INIT = 0;

    logic          clk_i = 1'b0;
    logic          async_rst_i = 1'b1;
    logic          sync_rst_i = 1'b0;
    logic          p_stb [2];
    logic          p_sel [2];
    logic [W-1:0]  p_a   [2];
    logic [W-1:0]  p_b   [2];

    logic          req0_ack_o, req1_ack_o;
    logic [RW-1:0] req0_res_o, req1_res_o;
    logic          arb2dsp_mul_sel_o;
    logic [W-1:0]  arb2dsp_mul_opd0_o, arb2dsp_mul_opd1_o;
    logic [RW-1:0] dsp2arb_mul_res_i;
    logic          arb_busy_o;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    function automatic logic [RW-1:0] mul_ref(input logic sel, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        longint pa, pb;
        if (sel) begin
            pa = longint'($signed(a));
            pb = longint'($signed(b));
        end else begin
            pa = longint'(a);
            pb = longint'(b);
        end
        return RW'(pa * pb);
    endfunction

    // Stand-in for the DSP partition: combinational product of the registered operands.
    assign dsp2arb_mul_res_i = mul_ref(arb2dsp_mul_sel_o, arb2dsp_mul_opd0_o, arb2dsp_mul_opd1_o);

    n1_dsp_mul_arb #(.OPD_WIDTH(W), .RES_WIDTH(RW), .RR_INIT(RR_INIT)) dut (
        .clk_i              (clk_i),
        .async_rst_i        (async_rst_i),
        .sync_rst_i         (sync_rst_i),
        .req0_stb_i         (p_stb[0]),
        .req0_sel_i         (p_sel[0]),
        .req0_opd0_i        (p_a[0]),
        .req0_opd1_i        (p_b[0]),
        .req0_ack_o         (req0_ack_o),
        .req0_res_o         (req0_res_o),
        .req1_stb_i         (p_stb[1]),
        .req1_sel_i         (p_sel[1]),
        .req1_opd0_i        (p_a[1]),
        .req1_opd1_i        (p_b[1]),
        .req1_ack_o         (req1_ack_o),
        .req1_res_o         (req1_res_o),
        .arb2dsp_mul_sel_o  (arb2dsp_mul_sel_o),
        .arb2dsp_mul_opd0_o (arb2dsp_mul_opd0_o),
        .arb2dsp_mul_opd1_o (arb2dsp_mul_opd1_o),
        .dsp2arb_mul_res_i  (dsp2arb_mul_res_i),
        .arb_busy_o         (arb_busy_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Each accepted operation is remembered with the cycle its ack is due (grant + 2).
    typedef struct {
        int           port;
        int           due;
        logic [RW-1:0] prod;
        logic         sel;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } op_t;

    op_t           ops[$];
    int            cyc = 0;
    int            m_ptr;
    logic [RW-1:0] e_res [2];
    logic          e_sel;
    logic [W-1:0]  e_a, e_b;
    logic [1:0]    m_granted = '0;
    logic [1:0]    m_acked   = '0;

    task automatic model_clear();
        ops.delete();
        m_ptr    = RR_INIT;
        e_res[0] = '0;
        e_res[1] = '0;
        e_sel    = 1'b0;
        e_a      = '0;
        e_b      = '0;
    endtask

    initial begin : model
        op_t        keep[$];
        logic [1:0] e_ack, pend, elig;
        logic       e_busy;
        int         g;
        model_clear();
        forever begin
            @(negedge clk_i);
            cyc++;
            m_granted = '0;
            m_acked   = '0;
            if (async_rst_i) begin
                check("rst_ack0", req0_ack_o, 0);
                check("rst_ack1", req1_ack_o, 0);
                check("rst_res0", req0_res_o, 0);
                check("rst_res1", req1_res_o, 0);
                check("rst_sel",  arb2dsp_mul_sel_o, 0);
                check("rst_opd0", arb2dsp_mul_opd0_o, 0);
                check("rst_opd1", arb2dsp_mul_opd1_o, 0);
                check("rst_busy", arb_busy_o, 0);
                model_clear();
            end else begin
                e_ack  = '0;
                e_busy = 1'b0;
                pend   = '0;
                foreach (ops[i]) begin
                    if (ops[i].due == cyc) begin
                        e_ack[ops[i].port]   = 1'b1;
                        m_acked[ops[i].port] = 1'b1;
                        e_res[ops[i].port]   = ops[i].prod;
                        e_busy               = 1'b1;
                    end
                    if (ops[i].due == cyc + 1) begin
                        e_sel  = ops[i].sel;
                        e_a    = ops[i].a;
                        e_b    = ops[i].b;
                        e_busy = 1'b1;
                    end
                    if (ops[i].due >= cyc) pend[ops[i].port] = 1'b1;
                end
                check("m_ack0", req0_ack_o, e_ack[0]);
                check("m_ack1", req1_ack_o, e_ack[1]);
                check("m_res0", req0_res_o, e_res[0]);
                check("m_res1", req1_res_o, e_res[1]);
                check("m_sel",  arb2dsp_mul_sel_o, e_sel);
                check("m_opd0", arb2dsp_mul_opd0_o, e_a);
                check("m_opd1", arb2dsp_mul_opd1_o, e_b);
                check("m_busy", arb_busy_o, e_busy);

                keep.delete();
                foreach (ops[i]) if (ops[i].due > cyc) keep.push_back(ops[i]);
                ops = keep;

                if (sync_rst_i) begin
                    model_clear();
                end else begin
                    elig = {p_stb[1] & ~pend[1], p_stb[0] & ~pend[0]};
                    g = -1;
                    if (elig == 2'b11)     g = m_ptr;
                    else if (elig[0])      g = 0;
                    else if (elig[1])      g = 1;
                    if (g >= 0) begin
                        m_ptr        = 1 - g;
                        m_granted[g] = 1'b1;
                        ops.push_back('{port: g, due: cyc + 2,
                                        prod: mul_ref(p_sel[g], p_a[g], p_b[g]),
                                        sel: p_sel[g], a: p_a[g], b: p_b[g]});
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input int n, input logic stb, input logic sel,
                           input logic [W-1:0] a, input logic [W-1:0] b);
        p_stb[n] = stb;
        p_sel[n] = sel;
        p_a[n]   = a;
        p_b[n]   = b;
    endtask

    function automatic logic [W-1:0] rnd16();
        case ($urandom_range(5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin : main
        int cnt;
        int rs [2];
        for (int n = 0; n < 2; n++) set_req(n, 0, 0, '0, '0);

        repeat (3) tick();
        check("reset_busy", arb_busy_o, 0);
        check("reset_res0", req0_res_o, 0);
        async_rst_i = 1'b0;
        tick();

        // Unsigned request on port 0
        set_req(0, 1, 0, 16'h0003, 16'h0004);
        tick();
        check("t1_opd0", arb2dsp_mul_opd0_o, 16'h0003);
        check("t1_ack_early", req0_ack_o, 0);
        tick();
        check("t1_ack", req0_ack_o, 1);
        check("t1_res", req0_res_o, 32'h0000000C);
        p_stb[0] = 1'b0;
        tick();
        check("t1_ack_once", req0_ack_o, 0);

        // Signed request on port 1
        set_req(1, 1, 1, 16'hFFFF, 16'h0002);
        tick();
        check("t2_sel", arb2dsp_mul_sel_o, 1);
        tick();
        check("t2_ack", req1_ack_o, 1);
        check("t2_res", req1_res_o, 32'hFFFFFFFE);
        check("t2_ack0_quiet", req0_ack_o, 0);
        p_stb[1] = 1'b0;
        tick();

        // Contention straight after reset: port 0 first, port 1 one cycle later
        async_rst_i = 1'b1;
        tick();
        async_rst_i = 1'b0;
        set_req(0, 1, 0, 16'h0005, 16'h0006);
        set_req(1, 1, 0, 16'h0007, 16'h0008);
        tick();
        check("t3_first_opd0", arb2dsp_mul_opd0_o, 16'h0005);
        tick();
        check("t3_second_opd0", arb2dsp_mul_opd0_o, 16'h0007);
        check("t3_ack0", req0_ack_o, 1);
        check("t3_ack1_early", req1_ack_o, 0);
        check("t3_res0", req0_res_o, 32'h0000001E);
        p_stb[0] = 1'b0;
        p_stb[1] = 1'b0;
        tick();
        check("t3_ack1", req1_ack_o, 1);
        check("t3_ack0_once", req0_ack_o, 0);
        check("t3_res1", req1_res_o, 32'h00000038);
        tick();
        // Port 1's lone grant handed priority back to port 0
        set_req(0, 1, 0, 16'h0009, 16'h0001);
        set_req(1, 1, 0, 16'h0002, 16'h0002);
        tick();
        check("t3b_first_opd0", arb2dsp_mul_opd0_o, 16'h0009);
        tick();
        check("t3b_second_opd0", arb2dsp_mul_opd0_o, 16'h0002);
        p_stb[0] = 1'b0;
        p_stb[1] = 1'b0;
        repeat (3) tick();

        // Port 0 streams: one operation every 3 cycles
        set_req(0, 1, 0, 16'h0100, 16'h0011);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (req0_ack_o === 1'b1) cnt++;
        end
        p_stb[0] = 1'b0;
        check("t4_ack_count", cnt, 4);
        check("t4_res", req0_res_o, 32'h00001100);
        repeat (3) tick();

        // Operands change and strobe drops right after the grant
        set_req(1, 1, 0, 16'h1234, 16'h0010);
        tick();
        set_req(1, 0, 1, 16'hFFFF, 16'hFFFF);
        tick();
        check("t5_ack", req1_ack_o, 1);
        check("t5_res", req1_res_o, 32'h00012340);
        tick();
        check("t5_ack_once", req1_ack_o, 0);
        tick();

        // Asynchronous reset with both stages occupied
        set_req(0, 1, 0, 16'h0010, 16'h0010);
        set_req(1, 1, 1, 16'hFFFE, 16'h0003);
        tick();
        tick();
        async_rst_i = 1'b1;
        #1;
        check("t6_busy_now", arb_busy_o, 0);
        check("t6_ack0_now", req0_ack_o, 0);
        check("t6_opd0_now", arb2dsp_mul_opd0_o, 0);
        check("t6_res0_now", req0_res_o, 0);
        tick();
        async_rst_i = 1'b0;
        check("t6_no_stale_ack1", req1_ack_o, 0);
        tick();
        check("t6_regrant_opd0", arb2dsp_mul_opd0_o, 16'h0010);
        check("t6_ack0_early", req0_ack_o, 0);
        tick();
        check("t6_ack0", req0_ack_o, 1);
        check("t6_res0", req0_res_o, 32'h00000100);
        p_stb[0] = 1'b0;
        p_stb[1] = 1'b0;
        tick();
        check("t6_ack1", req1_ack_o, 1);
        check("t6_res1", req1_res_o, 32'hFFFFFFFA);
        tick();

        // Synchronous reset while S1 is valid
        set_req(0, 1, 0, 16'h0002, 16'h0003);
        tick();
        sync_rst_i = 1'b1;
        tick();
        sync_rst_i = 1'b0;
        check("t7_busy", arb_busy_o, 0);
        check("t7_opd0", arb2dsp_mul_opd0_o, 0);
        tick();
        check("t7_regrant_opd0", arb2dsp_mul_opd0_o, 16'h0002);
        tick();
        check("t7_ack", req0_ack_o, 1);
        check("t7_res", req0_res_o, 32'h00000006);
        p_stb[0] = 1'b0;
        repeat (2) tick();

        // Random traffic: 0 idle, 1 waiting for grant, 2 waiting for ack
        rs[0] = 0;
        rs[1] = 0;
        repeat (800) begin
            tick();
            for (int n = 0; n < 2; n++) begin
                case (rs[n])
                    0: if ($urandom_range(99) < 45) begin
                        set_req(n, 1, 1'($urandom_range(1)), rnd16(), rnd16());
                        rs[n] = 1;
                    end
                    1: if (m_granted[n]) begin
                        rs[n] = 2;
                        if ($urandom_range(1) == 1) set_req(n, p_stb[n], ~p_sel[n], rnd16(), rnd16());
                        if ($urandom_range(2) == 0) p_stb[n] = 1'b0;
                    end
                    default: if (m_acked[n]) begin
                        if ($urandom_range(1) == 1) begin
                            set_req(n, 1, 1'($urandom_range(1)), rnd16(), rnd16());
                            rs[n] = 1;
                        end else begin
                            p_stb[n] = 1'b0;
                            rs[n]    = 0;
                        end
                    end
                endcase
            end
        end
        p_stb[0] = 1'b0;
        p_stb[1] = 1'b0;
        repeat (6) tick();
        check("end_idle", arb_busy_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
